// File: rtl/keypad_entry_ctrl_pkg.sv
// Shared types and constants for the keypad timer-entry path.
package keypad_entry_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDebPress,
    StHeld,
    StDebRel
  } deb_state_e;

  typedef logic [3:0] bcd_t;

  localparam int unsigned NUM_DIGITS = 3;

endpackage

// File: rtl/keypad_entry_ctrl_key_debounce.sv
// Press/release debouncer for the encoded keypad digit; emits one accept pulse per press.
module keypad_entry_ctrl_key_debounce
  import keypad_entry_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned CNT_W      = $clog2(DEB_CYCLES + 1)
) (
  input  logic clk_i,
  input  logic resetn_i,
  input  bcd_t key_i,
  input  logic all_off_i,
  output logic accept_o,
  output bcd_t cand_o
);

  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntDone = CNT_W'(DEB_CYCLES);

  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  bcd_t             cand_q, cand_d;

  assign cnt_inc = cnt_q + CntOne;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    accept_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!all_off_i) begin
          cand_d = key_i;
          cnt_d  = CntOne;
          // A single-cycle debounce accepts on the very first pressed sample.
          if (CntOne == CntDone) begin
            accept_o = 1'b1;
            state_d  = StHeld;
          end else begin
            state_d = StDebPress;
          end
        end
      end
      StDebPress: begin
        if (all_off_i || (key_i != cand_q)) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntDone) begin
            accept_o = 1'b1;
            state_d  = StHeld;
          end
        end
      end
      StHeld: begin
        if (all_off_i) begin
          cnt_d   = CntOne;
          state_d = (CntOne == CntDone) ? StIdle : StDebRel;
        end
      end
      StDebRel: begin
        if (!all_off_i) begin
          cnt_d   = '0;
          state_d = StHeld;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntDone) begin
            cnt_d   = '0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Accept from idle must present the live key, so expose the next-state candidate.
  assign cand_o = cand_d;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Keypad timer-entry controller: debounced digit entry into an M:SS register and timer load.
module keypad_entry_ctrl
  import keypad_entry_ctrl_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned CNT_W      = $clog2(DEB_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] D,
  input  logic       all_off,
  input  logic       busy,
  input  logic       start,
  input  logic       clearn,
  output logic [3:0] min_o,
  output logic [3:0] sec_t,
  output logic [3:0] sec_o,
  output logic [1:0] n_digits,
  output logic       key_valid,
  output logic       load
);

  logic accept;
  bcd_t cand;

  keypad_entry_ctrl_key_debounce #(
    .DEB_CYCLES(DEB_CYCLES),
    .CNT_W     (CNT_W)
  ) u_key_debounce (
    .clk_i    (clk),
    .resetn_i (resetn),
    .key_i    (D),
    .all_off_i(all_off),
    .accept_o (accept),
    .cand_o   (cand)
  );

  bcd_t       dig_q [NUM_DIGITS];
  bcd_t       dig_d [NUM_DIGITS];
  logic [1:0] n_q, n_d;
  logic       kv_q, kv_d;
  logic       start_q;

  // Clear outranks load; load outranks an accept landing in the same cycle.
  assign load = resetn && clearn && start && !start_q && !busy && (n_q != 2'd0);

  always_comb begin
    dig_d = dig_q;
    n_d   = n_q;
    kv_d  = 1'b0;
    if (!clearn || load) begin
      dig_d = '{default: '0};
      n_d   = 2'd0;
    end else if (accept && !busy) begin
      for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
        dig_d[i] = dig_q[i-1];
      end
      dig_d[0] = cand;
      n_d      = (n_q == 2'(NUM_DIGITS)) ? n_q : n_q + 2'd1;
      kv_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dig_q   <= '{default: '0};
      n_q     <= 2'd0;
      kv_q    <= 1'b0;
      start_q <= 1'b0;
    end else begin
      dig_q   <= dig_d;
      n_q     <= n_d;
      kv_q    <= kv_d;
      start_q <= start;
    end
  end

  assign sec_o     = dig_q[0];
  assign sec_t     = dig_q[1];
  assign min_o     = dig_q[2];
  assign n_digits  = n_q;
  assign key_valid = kv_q;

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl with a run-length behavioural model checked every cycle.
module tb_keypad_entry_ctrl;

  localparam int unsigned DEB = 4;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] D = 4'd0;
  logic       all_off = 1'b1;
  logic       busy = 1'b0;
  logic       start = 1'b0;
  logic       clearn = 1'b1;
  logic [3:0] min_o, sec_t, sec_o;
  logic [1:0] n_digits;
  logic       key_valid, load;

  always #5 clk = ~clk;

  keypad_entry_ctrl #(
    .DEB_CYCLES(DEB)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .D        (D),
    .all_off  (all_off),
    .busy     (busy),
    .start    (start),
    .clearn   (clearn),
    .min_o    (min_o),
    .sec_t    (sec_t),
    .sec_o    (sec_o),
    .n_digits (n_digits),
    .key_valid(key_valid),
    .load     (load)
  );

  int checks = 0;
  int errors = 0;

  // Model: entered digits (index 0 newest), press/release run lengths, armed = key released.
  int m_dig[3] = '{0, 0, 0};
  int m_n = 0;
  bit m_kv = 0;
  bit m_start_q = 0;
  bit m_armed = 1;
  int m_run = 0;
  int m_rel = 0;
  int m_cand = 0;
  bit chk_en = 0;

  int kv_count = 0;
  int ld_count = 0;
  int ld_min = -1, ld_t = -1, ld_o = -1;
  int kv0, ld0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit model_load();
    return resetn && clearn && start && !m_start_q && !busy && (m_n != 0);
  endfunction

  task automatic model_edge();
    bit acc = 0;
    bit ld  = model_load();
    if (!resetn) begin
      m_dig = '{0, 0, 0};
      m_n = 0; m_kv = 0; m_start_q = 0;
      m_armed = 1; m_run = 0; m_rel = 0;
      return;
    end
    if (m_armed) begin
      if (all_off) m_run = 0;
      else if (m_run == 0) begin
        m_cand = int'(D);
        m_run = 1;
      end else if (int'(D) != m_cand) m_run = 0;
      else m_run++;
      if (m_run == int'(DEB)) begin
        acc = 1; m_armed = 0; m_run = 0; m_rel = 0;
      end
    end else begin
      if (all_off) m_rel++;
      else m_rel = 0;
      if (m_rel == int'(DEB)) begin
        m_armed = 1; m_rel = 0;
      end
    end
    m_start_q = start;
    if (!clearn || ld) begin
      m_dig = '{0, 0, 0};
      m_n = 0;
      m_kv = 0;
    end else if (acc && !busy) begin
      m_dig[2] = m_dig[1];
      m_dig[1] = m_dig[0];
      m_dig[0] = m_cand;
      m_n = (m_n < 3) ? m_n + 1 : 3;
      m_kv = 1;
    end else begin
      m_kv = 0;
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  task automatic press(int d, int hold);
    D = 4'(d);
    all_off = 1'b0;
    step(hold);
    all_off = 1'b1;
    step(8);
  endtask

  task automatic clear_entry();
    clearn = 1'b0;
    step(1);
    clearn = 1'b1;
    step(1);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("min_o", 32'(min_o), 32'(m_dig[2]));
      check("sec_t", 32'(sec_t), 32'(m_dig[1]));
      check("sec_o", 32'(sec_o), 32'(m_dig[0]));
      check("n_digits", 32'(n_digits), 32'(m_n));
      check("key_valid", 32'(key_valid), 32'(m_kv));
      check("load", 32'(load), 32'(model_load()));
      if (key_valid === 1'b1) kv_count++;
      if (load === 1'b1) begin
        ld_count++;
        ld_min = int'(min_o);
        ld_t = int'(sec_t);
        ld_o = int'(sec_o);
      end
    end
  end

  initial begin
    step(2);
    chk_en = 1;
    check("rst_n_digits", 32'(n_digits), 0);
    check("rst_key_valid", 32'(key_valid), 0);
    check("rst_load", 32'(load), 0);
    check("rst_digits", {20'd0, min_o, sec_t, sec_o}, 0);
    resetn = 1'b1;
    step(2);

    // Single clean press held well past the debounce window.
    kv0 = kv_count;
    press(5, 10);
    check("t1_one_accept", 32'(kv_count - kv0), 1);
    check("t1_sec_o", 32'(sec_o), 5);
    check("t1_n", 32'(n_digits), 1);

    // Contact bounce shorter than the window, then a stable press.
    kv0 = kv_count;
    D = 4'd3;
    for (int i = 0; i < 12; i++) begin
      all_off = 1'((i / 2) % 2);
      step(1);
    end
    all_off = 1'b0;
    step(6);
    all_off = 1'b1;
    step(8);
    check("t2_one_accept", 32'(kv_count - kv0), 1);
    check("t2_sec_o", 32'(sec_o), 3);
    check("t2_sec_t", 32'(sec_t), 5);

    // Four digits: oldest shifts out, count saturates.
    clear_entry();
    press(1, 6); press(2, 6); press(3, 6); press(4, 6);
    check("t3_min", 32'(min_o), 2);
    check("t3_sec_t", 32'(sec_t), 3);
    check("t3_sec_o", 32'(sec_o), 4);
    check("t3_n", 32'(n_digits), 3);

    // Start pulse loads 1:30, then the entry clears.
    clear_entry();
    press(1, 6); press(3, 6); press(0, 6);
    ld0 = ld_count;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    check("t4_one_load", 32'(ld_count - ld0), 1);
    check("t4_ld_min", 32'(ld_min), 1);
    check("t4_ld_sec_t", 32'(ld_t), 3);
    check("t4_ld_sec_o", 32'(ld_o), 0);
    check("t4_n_after", 32'(n_digits), 0);
    check("t4_dig_after", {20'd0, min_o, sec_t, sec_o}, 0);
    press(8, 6);
    ld0 = ld_count;
    start = 1'b1;
    step(20);
    start = 1'b0;
    step(2);
    check("t4_held_start", 32'(ld_count - ld0), 1);

    // Busy lockout; a key still held when busy drops is not re-accepted.
    kv0 = kv_count;
    busy = 1'b1;
    D = 4'd7;
    all_off = 1'b0;
    step(8);
    busy = 1'b0;
    step(5);
    all_off = 1'b1;
    step(8);
    check("t5_busy_no_kv", 32'(kv_count - kv0), 0);
    check("t5_busy_n", 32'(n_digits), 0);
    kv0 = kv_count;
    press(7, 6);
    check("t5_after_kv", 32'(kv_count - kv0), 1);
    check("t5_after_sec_o", 32'(sec_o), 7);

    // Clear and start edge together: clear wins, no load.
    ld0 = ld_count;
    clearn = 1'b0;
    start = 1'b1;
    step(1);
    clearn = 1'b1;
    start = 1'b0;
    step(2);
    check("t6_no_load", 32'(ld_count - ld0), 0);
    check("t6_n", 32'(n_digits), 0);

    // Start edge on the accept edge: load sees pre-shift digits, the new digit is dropped.
    press(2, 6);
    kv0 = kv_count;
    ld0 = ld_count;
    D = 4'd6;
    all_off = 1'b0;
    step(3);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    all_off = 1'b1;
    step(8);
    check("t6_acc_load", 32'(ld_count - ld0), 1);
    check("t6_acc_ld_o", 32'(ld_o), 2);
    check("t6_acc_no_kv", 32'(kv_count - kv0), 0);
    check("t6_acc_n", 32'(n_digits), 0);

    // Reset mid-press restarts the debounce from scratch.
    D = 4'd6;
    all_off = 1'b0;
    step(2);
    resetn = 1'b0;
    step(1);
    resetn = 1'b1;
    kv0 = kv_count;
    step(3);
    check("t7_no_early_kv", 32'(kv_count - kv0), 0);
    step(5);
    check("t7_fresh_kv", 32'(kv_count - kv0), 1);
    check("t7_sec_o", 32'(sec_o), 6);
    all_off = 1'b1;
    step(8);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_entry_ctrl.md
Name: keypad_entry_ctrl

Overview:
- Sequences the keypad priority encoder for the microwave timer-entry path.
- Debounces the encoded key (D, all_off) and accepts one digit per physical press.
- Shifts accepted digits into a 3-digit M:SS entry register.
- On start, hands the register to the countdown timer with a one-cycle load pulse.
- Sits between the keypad encoder and the timer counter.

Parameters:
- DEB_CYCLES, 4, consecutive stable cycles required to accept a press and, separately, a release (minimum 1).
- CNT_W, $clog2(DEB_CYCLES+1), debounce counter width (derived; do not override).

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  synchronous, active-low reset
- D  in  4  encoded key digit from the keypad encoder (0-9)
- all_off  in  1  1 = no key pressed
- busy  in  1  timer running; digit entry and start are locked out
- start  in  1  level; request load of the entry register into the timer
- clearn  in  1  active-low, synchronous; clears the entry register
- min_o  out  4  minutes digit
- sec_t  out  4  seconds-tens digit
- sec_o  out  4  seconds-ones digit
- n_digits  out  2  digits entered since last clear/load, saturates at 3
- key_valid  out  1  one-cycle pulse when a digit is shifted in
- load  out  1  one-cycle pulse; min_o/sec_t/sec_o are valid for the timer this cycle

Behaviour:
- Reset (resetn=0 at a clk edge): state=IDLE, counter=0, all digits=0, n_digits=0, key_valid=0, load=0. Reset mid-debounce discards the press in progress.
- FSM states:
  - IDLE: all_off=0 → latch D into cand, cnt=1, go to DEB_PRESS.
  - DEB_PRESS:
    - all_off=1, or D≠cand → IDLE.
    - Otherwise cnt++. When cnt reaches DEB_CYCLES → accept and go to HELD.
  - HELD: all_off=1 → cnt=1, go to DEB_REL.
  - DEB_REL:
    - all_off=0 → HELD.
    - Otherwise cnt++. When cnt reaches DEB_CYCLES → IDLE.
- Latency: with DEB_CYCLES=1, accept occurs on the edge after the first cycle all_off=0 is seen; key_valid is registered and asserts in the following cycle.
- Accept (busy=0):
  - min_o←sec_t, sec_t←sec_o, sec_o←cand.
  - n_digits←min(n_digits+1,3).
  - key_valid=1 for exactly one cycle.
- Digits beyond 3 shift the oldest digit out; n_digits stays 3.
- Accept while busy=1: no shift, no key_valid. The FSM still proceeds to HELD, so a held key is not re-accepted when busy drops.
- Holding a key produces exactly one accept. Changing D while held produces no new accept until release has been debounced.
- Start:
  - Rising edge of start (registered start_d) with busy=0 and n_digits≠0 → load=1 for one cycle, with outputs showing the current digits.
  - Next cycle: digits and n_digits clear to 0.
  - start with n_digits=0 or busy=1 → ignored.
  - A level held high loads only once.
- Priorities within one cycle, highest first: resetn, clearn, start/load, key accept.
  - clearn=0 and start edge in the same cycle → clear, no load.
  - Start edge and accept in the same cycle → load uses pre-shift digits; the accepted digit is discarded, with no key_valid.
- No range check on sec_t (>5 permitted). Normalisation belongs to the timer.
- Digits are 4-bit BCD. D is taken as 0-9; values 10-15 are shifted unchanged.

Decomposition:
- Shared package:
  - FSM state typedef (IDLE, DEB_PRESS, HELD, DEB_REL).
  - BCD digit typedef (4 bits).
  - Constant NUM_DIGITS=3.
- One natural sub-module: key_debounce (FSM + counter; outputs a single accept pulse and cand).
- The shift register, n_digits and load logic stay in the top module.

Test Plan:
- DEB_CYCLES=4; press key 5 (D=5, all_off=0) held 10 cycles, then release → exactly one key_valid; sec_o=5, n_digits=1.
- Bounce: all_off toggles 0/1 every 2 cycles for 12 cycles, then stable 0 for 6 cycles with D=3 → single accept; sec_o=3.
- Enter 1,2,3,4 (each press/release debounced) → min_o=2, sec_t=3, sec_o=4, n_digits=3.
- With digits 1,3,0: pulse start → load=1 for one cycle with min_o=1, sec_t=3, sec_o=0; next cycle all digits 0, n_digits=0. Start held high 20 cycles → one load only.
- busy=1 while pressing 7 → no key_valid, digits unchanged. Deassert busy while still held → still no accept; release then press 7 → accept.
- Same-cycle cases:
  - clearn=0 with start edge → no load, digits 0.
  - resetn=0 during DEB_PRESS → state IDLE and no accept after reset release while the key is still held until cnt completes afresh.
